alu_issue_stage: RTL and testbench

Operand/opcode issue stage sitting directly upstream of the 32-bit ALU (`yAlu`). It accepts operand pairs plus an R-type `funct` field from decode over a valid/ready handshake and translates `funct` into the ALU's 3-bit `op`. It buffers entries in a small FIFO and presents them to the ALU/execute stage over a second valid/ready handshake. Illegal `funct` codes are consumed, dropped and flagged; issued operations are counted.

---
 rtl/alu_issue_stage_if.sv | 34 +++
 rtl/alu_issue_stage.sv | 148 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// -----------------------------------------------------------------------------
// alu_issue_stage_if
// Groups the two valid/ready handshakes around the ALU issue stage.
//   in_*  : decode -> issue stage (operand pair plus R-type funct)
//   out_* : issue stage -> ALU/execute (operand pair plus 3-bit ALU op)
// Modports:
//   slave  : the issue stage itself (accepts in_*, produces out_*)
//   master : the surrounding environment (decode + execute)
// -----------------------------------------------------------------------------
interface alu_issue_stage_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [5:0]       in_funct;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic [2:0]       out_op;

   modport slave (
      input  in_valid, in_a, in_b, in_funct, out_ready,
      output in_ready, out_valid, out_a, out_b, out_op
   );

   modport master (
      output in_valid, in_a, in_b, in_funct, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_op
   );
endinterface

// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
// Issue stage in front of the 32-bit ALU. Accepts operand pairs plus an R-type
// funct from decode, translates funct into the ALU's 3-bit op, buffers legal
// entries in a small circular FIFO and presents the head to execute.
// Illegal funct codes complete the input handshake but are dropped and flagged.
//
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous active-high reset
//   bus            : alu_issue_stage_if.slave (in_* / out_* handshakes)
//   illegal        : one-cycle pulse the cycle after an illegal entry is taken
//   illegal_sticky : set by any illegal entry, cleared only by rst
//   issue_count    : number of output handshakes, modulo 2^CNT_W
// -----------------------------------------------------------------------------
module alu_issue_stage #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   alu_issue_stage_if.slave bus,
   output logic             illegal,
   output logic             illegal_sticky,
   output logic [CNT_W-1:0] issue_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [2:0]       op;
   } entry_t;

   // Returns {legal, op}; anything outside the five supported R-type codes is illegal.
   function automatic logic [3:0] decode_funct(input logic [5:0] funct);
      logic [3:0] res;
      case (funct)
         6'h24:   res = {1'b1, 3'b000};  // AND
         6'h25:   res = {1'b1, 3'b001};  // OR
         6'h20:   res = {1'b1, 3'b010};  // ADD
         6'h22:   res = {1'b1, 3'b110};  // SUB
         6'h2A:   res = {1'b1, 3'b111};  // SLT
         default: res = {1'b0, 3'b000};
      endcase
      return res;
   endfunction

   entry_t           mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [OCC_W-1:0] occ_r;
   logic             illegal_r;
   logic             illegal_sticky_r;
   logic [CNT_W-1:0] issue_count_r;

   logic             full_s;
   logic             empty_s;
   logic [3:0]       dec_s;
   logic             accept_s;
   logic             push_s;
   logic             drop_s;
   logic             pop_s;
   entry_t           head_s;

   // Handshake qualification; ready/valid come from registered occupancy only.
   always_comb begin
      full_s   = (occ_r == OCC_FULL);
      empty_s  = (occ_r == {OCC_W{1'b0}});
      dec_s    = decode_funct(bus.in_funct);
      accept_s = bus.in_valid & ~full_s;
      push_s   = accept_s & dec_s[3];
      drop_s   = accept_s & ~dec_s[3];
      pop_s    = ~empty_s & bus.out_ready;
   end

   // Head entry is zeroed whenever nothing is buffered.
   always_comb begin
      head_s = mem_r[rd_ptr_r];
      if (empty_s) begin
         bus.out_a  = {WIDTH{1'b0}};
         bus.out_b  = {WIDTH{1'b0}};
         bus.out_op = 3'b000;
      end else begin
         bus.out_a  = head_s.a;
         bus.out_b  = head_s.b;
         bus.out_op = head_s.op;
      end
      bus.in_ready  = ~full_s;
      bus.out_valid = ~empty_s;
   end

   // FIFO storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= '{a: bus.in_a, b: bus.in_b, op: dec_s[2:0]};
      end
   end

   // Pointers and occupancy; both pointers wrap naturally at DEPTH (power of two).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         occ_r    <= {OCC_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   occ_r <= occ_r + OCC_ONE;
            2'b01:   occ_r <= occ_r - OCC_ONE;
            default: occ_r <= occ_r;
         endcase
      end
   end

   // Illegal-funct flags and the issue counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_r        <= 1'b0;
         illegal_sticky_r <= 1'b0;
         issue_count_r    <= {CNT_W{1'b0}};
      end else begin
         illegal_r        <= drop_s;
         illegal_sticky_r <= illegal_sticky_r | drop_s;
         if (pop_s) begin
            issue_count_r <= issue_count_r + CNT_ONE;
         end
      end
   end

   assign illegal        = illegal_r;
   assign illegal_sticky = illegal_sticky_r;
   assign issue_count    = issue_count_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
// Directed scenarios plus a constrained-random stream for alu_issue_stage.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

   localparam int WIDTH = 32;
   localparam int DEPTH = 2;
   localparam int CNT_W = 16;

   logic             clk;
   logic             rst;
   logic             illegal;
   logic             illegal_sticky;
   logic [CNT_W-1:0] issue_count;

   int npass;
   int nchk;

   alu_issue_stage_if #(.WIDTH(WIDTH)) bus ();

   alu_issue_stage #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .CNT_W(CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .illegal        (illegal),
      .illegal_sticky (illegal_sticky),
      .issue_count    (issue_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
      bus.in_valid = v;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_funct = f;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 6'h00);
      bus.out_ready = 1'b0;
      tick();
      tick();
      nchk++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else npass++;
      nchk++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else npass++;
      nchk++; if (bus.out_a !== 32'h0 || bus.out_b !== 32'h0) $display("FAIL reset_out_ab got=%h/%h exp=0/0", bus.out_a, bus.out_b); else npass++;
      nchk++; if (bus.out_op !== 3'b000) $display("FAIL reset_out_op got=%b exp=000", bus.out_op); else npass++;
      nchk++; if (illegal !== 1'b0 || illegal_sticky !== 1'b0) $display("FAIL reset_illegal got=%b/%b exp=0/0", illegal, illegal_sticky); else npass++;
      nchk++; if (issue_count !== 16'd0) $display("FAIL reset_issue_count got=%0d exp=0", issue_count); else npass++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_and();
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h0000_00F0, 32'h0000_003C, 6'h24);
      tick();
      drive(1'b0, 32'h0, 32'h0, 6'h00);
      nchk++; if (bus.out_valid !== 1'b1) $display("FAIL and_out_valid got=%b exp=1", bus.out_valid); else npass++;
      nchk++; if (bus.out_op !== 3'b000) $display("FAIL and_out_op got=%b exp=000", bus.out_op); else npass++;
      nchk++; if (bus.out_a !== 32'h0000_00F0 || bus.out_b !== 32'h0000_003C) $display("FAIL and_operands got=%h/%h exp=000000f0/0000003c", bus.out_a, bus.out_b); else npass++;
      nchk++; if (issue_count !== 16'd0) $display("FAIL and_count_before_pop got=%0d exp=0", issue_count); else npass++;
      tick();
      nchk++; if (bus.out_valid !== 1'b0) $display("FAIL and_drained got=%b exp=0", bus.out_valid); else npass++;
      nchk++; if (issue_count !== 16'd1) $display("FAIL and_issue_count got=%0d exp=1", issue_count); else npass++;
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h1, 32'h2, 6'h20);   // ADD
      tick();
      nchk++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready_after_1 got=%b exp=1", bus.in_ready); else npass++;
      drive(1'b1, 32'h3, 32'h4, 6'h22);   // SUB
      tick();
      nchk++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_full_after_2 got=%b exp=0", bus.in_ready); else npass++;
      drive(1'b1, 32'h5, 32'h6, 6'h25);   // OR, stalled while full
      tick();
      nchk++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_stays_full got=%b exp=0", bus.in_ready); else npass++;
      nchk++; if (bus.out_op !== 3'b010 || bus.out_a !== 32'h1 || bus.out_b !== 32'h2) $display("FAIL b2b_head_add got=%b/%h/%h exp=010/1/2", bus.out_op, bus.out_a, bus.out_b); else npass++;
      // Full with out_ready=1: one pop, no accept this cycle.
      bus.out_ready = 1'b1;
      tick();
      nchk++; if (bus.out_op !== 3'b110 || bus.out_a !== 32'h3 || bus.out_b !== 32'h4) $display("FAIL b2b_head_sub got=%b/%h/%h exp=110/3/4", bus.out_op, bus.out_a, bus.out_b); else npass++;
      nchk++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready_after_pop got=%b exp=1", bus.in_ready); else npass++;
      nchk++; if (issue_count !== 16'd2) $display("FAIL b2b_count_2 got=%0d exp=2", issue_count); else npass++;
      tick();  // OR accepted, SUB popped
      nchk++; if (bus.out_op !== 3'b001 || bus.out_a !== 32'h5 || bus.out_b !== 32'h6) $display("FAIL b2b_head_or got=%b/%h/%h exp=001/5/6", bus.out_op, bus.out_a, bus.out_b); else npass++;
      drive(1'b1, 32'h7, 32'h8, 6'h2A);   // SLT
      tick();
      drive(1'b0, 32'h0, 32'h0, 6'h00);
      nchk++; if (bus.out_op !== 3'b111 || bus.out_a !== 32'h7 || bus.out_b !== 32'h8) $display("FAIL b2b_head_slt got=%b/%h/%h exp=111/7/8", bus.out_op, bus.out_a, bus.out_b); else npass++;
      tick();
      nchk++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_empty got=%b exp=0", bus.out_valid); else npass++;
      nchk++; if (issue_count !== 16'd5) $display("FAIL b2b_issue_count got=%0d exp=5", issue_count); else npass++;
   endtask

   task automatic test_illegal();
      bus.out_ready = 1'b1;
      drive(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 6'h00);
      nchk++; if (bus.in_ready !== 1'b1) $display("FAIL ill_ready got=%b exp=1", bus.in_ready); else npass++;
      tick();
      drive(1'b0, 32'h0, 32'h0, 6'h00);
      nchk++; if (illegal !== 1'b1) $display("FAIL ill_pulse got=%b exp=1", illegal); else npass++;
      nchk++; if (bus.out_valid !== 1'b0) $display("FAIL ill_not_written got=%b exp=0", bus.out_valid); else npass++;
      nchk++; if (illegal_sticky !== 1'b1) $display("FAIL ill_sticky_set got=%b exp=1", illegal_sticky); else npass++;
      tick();
      nchk++; if (illegal !== 1'b0) $display("FAIL ill_pulse_one_cycle got=%b exp=0", illegal); else npass++;
      nchk++; if (illegal_sticky !== 1'b1) $display("FAIL ill_sticky_hold got=%b exp=1", illegal_sticky); else npass++;
      // Two illegal entries back to back.
      drive(1'b1, 32'h0, 32'h0, 6'h3F);
      tick();
      nchk++; if (illegal !== 1'b1) $display("FAIL ill_b2b_first got=%b exp=1", illegal); else npass++;
      tick();
      drive(1'b0, 32'h0, 32'h0, 6'h00);
      nchk++; if (illegal !== 1'b1) $display("FAIL ill_b2b_second got=%b exp=1", illegal); else npass++;
      tick();
      nchk++; if (illegal !== 1'b0) $display("FAIL ill_b2b_end got=%b exp=0", illegal); else npass++;
      // Illegal entry arriving while a pop happens.
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h9, 32'hA, 6'h24);
      tick();
      bus.out_ready = 1'b1;
      drive(1'b1, 32'hB, 32'hC, 6'h21);
      tick();
      drive(1'b0, 32'h0, 32'h0, 6'h00);
      nchk++; if (bus.out_valid !== 1'b0 || illegal !== 1'b1) $display("FAIL ill_with_pop got=%b/%b exp=0/1", bus.out_valid, illegal); else npass++;
      nchk++; if (issue_count !== 16'd6) $display("FAIL ill_with_pop_count got=%0d exp=6", issue_count); else npass++;
   endtask

   task automatic test_random();
      logic [5:0]        functs [5];
      logic [2:0]        ops    [5];
      logic [66:0]       q [$];
      logic [66:0]       exp_e;
      logic              push_fire;
      logic              pop_fire;
      logic [2:0]        cur_op;
      int                pushed;
      int                cyc;
      int                sel;
      functs = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h2A};
      ops    = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
      // Restart from reset so the counter ends exactly at the stream length.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      pushed = 0;
      cyc    = 0;
      cur_op = 3'b000;
      while ((pushed < 1000 || q.size() != 0) && cyc < 20000) begin
         if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
            sel = $urandom_range(0, 4);
            cur_op = ops[sel];
            drive(1'b1, $urandom, $urandom, functs[sel]);
         end else begin
            drive(1'b0, 32'h0, 32'h0, 6'h00);
         end
         bus.out_ready = ($urandom_range(0, 3) != 0);
         nchk++; if (bus.out_valid !== (q.size() != 0) || bus.in_ready !== (q.size() < DEPTH)) begin
            if (nchk - npass < 20) $display("FAIL rnd_flags cyc=%0d got v=%b r=%b exp occ=%0d", cyc, bus.out_valid, bus.in_ready, q.size());
         end else npass++;
         push_fire = bus.in_valid && bus.in_ready;
         pop_fire  = bus.out_valid && bus.out_ready;
         if (pop_fire && q.size() != 0) begin
            exp_e = q.pop_front();
            nchk++; if ({bus.out_a, bus.out_b, bus.out_op} !== exp_e) begin
               if (nchk - npass < 20) $display("FAIL rnd_data cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc, bus.out_a, bus.out_b, bus.out_op, exp_e[66:35], exp_e[34:3], exp_e[2:0]);
            end else npass++;
         end
         if (push_fire) begin
            q.push_back({bus.in_a, bus.in_b, cur_op});
            pushed++;
         end
         tick();
         cyc++;
      end
      drive(1'b0, 32'h0, 32'h0, 6'h00);
      nchk++; if (cyc >= 20000) $display("FAIL rnd_timeout pushed=%0d left=%0d exp=done", pushed, q.size()); else npass++;
      nchk++; if (issue_count !== 16'd1000) $display("FAIL rnd_issue_count got=%0d exp=1000", issue_count); else npass++;
   endtask

   task automatic test_async_reset();
      bus.out_ready = 1'b0;
      drive(1'b1, 32'h0, 32'h0, 6'h00);   // illegal, sets sticky
      tick();
      drive(1'b1, 32'h11, 32'h12, 6'h20);
      tick();
      drive(1'b1, 32'h22, 32'h23, 6'h25);
      tick();
      drive(1'b0, 32'h0, 32'h0, 6'h00);
      nchk++; if (bus.in_ready !== 1'b0 || illegal_sticky !== 1'b1) $display("FAIL arst_pre got=%b/%b exp=0/1", bus.in_ready, illegal_sticky); else npass++;
      #3;
      rst = 1'b1;
      #1;
      nchk++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL arst_immediate got=%b/%b exp=0/1", bus.out_valid, bus.in_ready); else npass++;
      nchk++; if (bus.out_a !== 32'h0 || bus.out_op !== 3'b000) $display("FAIL arst_outputs got=%h/%b exp=0/000", bus.out_a, bus.out_op); else npass++;
      nchk++; if (illegal_sticky !== 1'b0 || issue_count !== 16'd0) $display("FAIL arst_flags got=%b/%0d exp=0/0", illegal_sticky, issue_count); else npass++;
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b1, 32'h33, 32'h34, 6'h24);
      tick();
      drive(1'b0, 32'h0, 32'h0, 6'h00);
      nchk++; if (bus.out_valid !== 1'b1 || bus.out_a !== 32'h33 || bus.out_b !== 32'h34) $display("FAIL arst_first_push got=%b/%h/%h exp=1/33/34", bus.out_valid, bus.out_a, bus.out_b); else npass++;
      tick();
      nchk++; if (bus.out_valid !== 1'b0 || issue_count !== 16'd1) $display("FAIL arst_alone got=%b/%0d exp=0/1", bus.out_valid, issue_count); else npass++;
   endtask

   initial begin
      npass = 0;
      nchk  = 0;
      test_reset();
      test_single_and();
      test_back_to_back();
      test_illegal();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
